// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU front end.
package hack_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W = 2;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // PC increment; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/hack_fetch_if.sv
// Fetch-stage bus: ROM read port, redirect from execute, and the decode handshake.
interface hack_fetch_if;
  import hack_pkg::*;

  logic                jump;
  logic [ADDR_W-1:0]   jump_addr;
  logic [ADDR_W-1:0]   rom_addr;
  logic [INSTR_W-1:0]  rom_data;
  logic [INSTR_W-1:0]  instr;
  logic [ADDR_W-1:0]   instr_pc;
  logic                instr_valid;
  logic                instr_ready;

  modport master (
    input  jump, jump_addr, rom_data, instr_ready,
    output rom_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output jump, jump_addr, rom_data, instr_ready,
    input  rom_addr, instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched {instr, pc}; the head entry feeds decode.
module fetch_skid_buffer
  import hack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [OCC_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t mem [FIFO_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: PC, ROM read issue, and a 2-entry skid buffer to decode.
// Optional STALL_COUNT_EN adds a saturating stall_cycles counter output.
module hack_fetch
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  hack_fetch_if.master bus
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]  stall_cycles
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  logic [OCC_W-1:0]  occ;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        load;

  assign valid = (occ != '0);
  assign pop   = valid & bus.instr_ready;

  // A returning read is dropped if a redirect lands in the same cycle.
  assign push  = inflight_q & ~bus.jump;
  assign push_data = '{instr: bus.rom_data, pc: inflight_pc_q};

  // Outstanding work after this cycle must fit the two buffer slots.
  assign load  = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign issue = (state == FETCH_RUN) && !bus.jump && (load < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH_IDLE;
      rom_addr_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      case (state)
        FETCH_IDLE: state <= FETCH_RUN;
        FETCH_RUN:  state <= FETCH_RUN;
        default:    state <= FETCH_IDLE;
      endcase

      if (bus.jump) begin
        rom_addr_q <= bus.jump_addr;
        inflight_q <= 1'b0;
      end else if (issue) begin
        rom_addr_q    <= pc_next(rom_addr_q);
        inflight_q    <= 1'b1;
        inflight_pc_q <= rom_addr_q;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  fetch_skid_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.jump),
    .count     (occ),
    .head      (head)
  );

  assign bus.rom_addr    = rom_addr_q;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = valid;

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (valid && !bus.instr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hack_fetch.sv
// Directed bench for hack_fetch: per-cycle vector table plus async reset and stall-counter sequences.
module tb_hack_fetch;
  import hack_pkg::*;

  typedef struct {
    logic               ready;
    logic               jump;
    logic [ADDR_W-1:0]  jaddr;
    logic               ev;
    logic [ADDR_W-1:0]  epc;
    logic [INSTR_W-1:0] einstr;
    logic [ADDR_W-1:0]  erom;
  } vec_t;

  localparam int NVEC = 34;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];
  int   nv = 0;

  always #5 clk = ~clk;

  hack_fetch_if bus ();

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  hack_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Synchronous ROM: ROM[a] = a + 0x100.
  always @(posedge clk) bus.rom_data <= 16'(bus.rom_addr) + 16'h0100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic j, input logic [ADDR_W-1:0] ja,
                     input logic ev, input logic [ADDR_W-1:0] epc,
                     input logic [ADDR_W-1:0] erom);
    vecs[nv] = '{ready: r, jump: j, jaddr: ja, ev: ev, epc: epc,
                 einstr: 16'(epc) + 16'h0100, erom: erom};
    nv++;
  endtask

  // Called at a negedge: compare this cycle's outputs, drive inputs, advance one cycle.
  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check($sformatf("v%0d valid", i), 32'(bus.instr_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d rom_addr", i), 32'(bus.rom_addr), 32'(vecs[i].erom));
      if (vecs[i].ev) begin
        check($sformatf("v%0d pc", i), 32'(bus.instr_pc), 32'(vecs[i].epc));
        check($sformatf("v%0d instr", i), 32'(bus.instr), 32'(vecs[i].einstr));
      end
      bus.instr_ready = vecs[i].ready;
      bus.jump        = vecs[i].jump;
      bus.jump_addr   = vecs[i].jaddr;
      @(negedge clk);
    end
  endtask

  initial begin
    // Startup, streaming with ready=1.
    add(1, 0, 0, 0, 0, 15'h0000);      // 0: IDLE
    add(1, 0, 0, 0, 0, 15'h0000);      // 1: first issue
    add(1, 0, 0, 0, 0, 15'h0001);
    add(1, 0, 0, 1, 15'h0000, 15'h0002);
    add(1, 0, 0, 1, 15'h0001, 15'h0003);
    add(1, 0, 0, 1, 15'h0002, 15'h0004);
    add(1, 0, 0, 1, 15'h0003, 15'h0005);
    add(1, 0, 0, 1, 15'h0004, 15'h0006);
    // Five stall cycles: head frozen, rom_addr two ahead.
    add(0, 0, 0, 1, 15'h0005, 15'h0007);
    add(0, 0, 0, 1, 15'h0005, 15'h0007);
    add(0, 0, 0, 1, 15'h0005, 15'h0007);
    add(0, 0, 0, 1, 15'h0005, 15'h0007);
    add(0, 0, 0, 1, 15'h0005, 15'h0007);
    add(1, 0, 0, 1, 15'h0005, 15'h0007);
    add(1, 0, 0, 1, 15'h0006, 15'h0008);
    add(1, 0, 0, 1, 15'h0007, 15'h0009);
    // Fill buffer, then jump to 0x0040 while full.
    add(0, 0, 0, 1, 15'h0008, 15'h000A);
    add(0, 1, 15'h0040, 1, 15'h0008, 15'h000A);
    add(1, 0, 0, 0, 0, 15'h0040);
    add(1, 0, 0, 0, 0, 15'h0041);
    add(1, 0, 0, 1, 15'h0040, 15'h0042);
    add(1, 0, 0, 1, 15'h0041, 15'h0043);
    // Jump with a transfer in the same cycle, target near the top of the address space.
    add(1, 1, 15'h7FFE, 1, 15'h0042, 15'h0044);
    add(1, 0, 0, 0, 0, 15'h7FFE);
    add(1, 0, 0, 0, 0, 15'h7FFF);
    add(1, 0, 0, 1, 15'h7FFE, 15'h0000);
    add(1, 0, 0, 1, 15'h7FFF, 15'h0001);
    add(1, 0, 0, 1, 15'h0000, 15'h0002);
    // Back-to-back jumps: 0x0100 is superseded by 0x0200.
    add(1, 1, 15'h0100, 1, 15'h0001, 15'h0003);
    add(1, 1, 15'h0200, 0, 0, 15'h0100);
    add(1, 0, 0, 0, 0, 15'h0200);
    add(1, 0, 0, 0, 0, 15'h0201);
    add(1, 0, 0, 1, 15'h0200, 15'h0202);
    add(1, 0, 0, 1, 15'h0201, 15'h0203);

    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_addr   = '0;
    repeat (3) @(negedge clk);
    check("reset valid", 32'(bus.instr_valid), 32'd0);
    check("reset rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset instr", 32'(bus.instr), 32'd0);
    check("reset pc", 32'(bus.instr_pc), 32'd0);
    rst = 1'b0;

    run_vecs(0, NVEC - 1);

    // Async reset mid-stream with a read in flight.
    check("pre-rst valid", 32'(bus.instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(bus.instr_valid), 32'd0);
    check("async rst rom_addr", 32'(bus.rom_addr), 32'd0);
    check("async rst pc", 32'(bus.instr_pc), 32'd0);
    check("async rst instr", 32'(bus.instr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_vecs(0, 7);

`ifdef STALL_COUNT_EN
    bus.instr_ready = 1'b0;
    repeat (70000) @(negedge clk);
    check("stall valid", 32'(bus.instr_valid), 32'd1);
    check("stall_cycles sat", 32'(stall_cycles), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
